// File: rtl/sevenseg_scan_ctrl.sv
// Scan controller for a common-anode seven-segment display: one digit per slot,
// guard blanking between digits, frame-boundary shadow updates, optional leading-zero blanking.
module sevenseg_scan_ctrl #(
  parameter int NDIG        = 8,
  parameter int DIV         = 100000,
  parameter int GUARD       = 1000,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 load,
  input  logic [7*NDIG-1:0]    digits_in,
  output logic [6:0]           data_out,
  output logic [NDIG-1:0]      an_n,
  output logic                 frame_done
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0] CNT_GLAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);
  localparam logic [6:0]    BLANK     = 7'h40;

  typedef enum logic {S_GUARD = 1'b0, S_ON = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [7*NDIG-1:0]   shadow_q, shadow_d;
  logic [7*NDIG-1:0]   pending_q, pending_d;
  logic                pend_valid_q, pend_valid_d;
  logic [NDIG-1:0]     an_n_q, an_n_d;
  logic [6:0]          data_out_q, data_out_d;
  logic                frame_done_q, frame_done_d;
  logic                wrap;
  logic [7*NDIG-1:0]   lz_frame;
  logic                keep;
  logic [NDIG-1:0]     sel_dec;

  // Walk from the most significant digit down; the first non-zero code stops blanking.
  always_comb begin
    lz_frame = digits_in;
    keep     = 1'b0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      keep = keep | (digits_in[7*i +: 7] != 7'h00);
      if (LZ_SUPPRESS != 0 && !keep) lz_frame[7*i +: 7] = BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_GUARD;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= {NDIG{BLANK}};
      pending_q    <= {NDIG{BLANK}};
      pend_valid_q <= 1'b0;
      an_n_q       <= '1;
      data_out_q   <= BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      an_n_q       <= an_n_d;
      data_out_q   <= data_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (en) begin
      case (state_q)
        S_GUARD: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_GLAST) state_d = S_ON;
        end
        S_ON: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_GUARD;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = S_GUARD;
      endcase
    end

    // A load on the wrap edge refills pending after the old pending was copied.
    shadow_d     = (wrap && pend_valid_q) ? pending_q : shadow_q;
    pend_valid_d = wrap ? 1'b0 : pend_valid_q;
    pending_d    = pending_q;
    if (load) begin
      pending_d    = lz_frame;
      pend_valid_d = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_dec
    assign sel_dec[gi] = (idx_d == IW'(gi));
  end

  // Outputs follow the next state so they change on the same edge as the counters.
  always_comb begin
    frame_done_d = wrap;
    an_n_d       = '1;
    data_out_d   = BLANK;
    if (en && state_d == S_ON) begin
      an_n_d     = ~sel_dec;
      data_out_d = shadow_d[7*idx_d +: 7];
    end
  end

  assign an_n       = an_n_q;
  assign data_out   = data_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: positional model (enabled-cycle count) plus directed literal checks.
module tb_sevenseg_scan_ctrl;
  localparam int N = 4;
  localparam int DV = 8;
  localparam int GD = 2;
  localparam int FRAME = N * DV;

  logic clk = 1'b0;
  logic rst_n, en, load;
  logic [27:0] digits;
  logic [6:0] data0, data1;
  logic [3:0] an0, an1;
  logic fd0, fd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(.NDIG(N), .DIV(DV), .GUARD(GD), .LZ_SUPPRESS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits),
    .data_out(data0), .an_n(an0), .frame_done(fd0));

  sevenseg_scan_ctrl #(.NDIG(N), .DIV(DV), .GUARD(GD), .LZ_SUPPRESS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits),
    .data_out(data1), .an_n(an1), .frame_done(fd1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] lz_proc(input logic [27:0] d, input bit lz);
    int top = 0;
    logic [27:0] r = d;
    for (int i = 0; i < N; i++) if (d[7*i +: 7] != 7'h00) top = i;
    if (lz) for (int i = 1; i < N; i++) if (i > top) r[7*i +: 7] = 7'h40;
    return r;
  endfunction

  // Model: position p = enabled edges since reset; slot/phase follow by division.
  int p;
  bit pv;
  logic [27:0] sh0, sh1, pd0, pd1;
  logic [3:0] exp_an;
  logic [6:0] exp_d0, exp_d1;
  bit exp_fd;
  bit s_en, s_load, s_rst;
  logic [27:0] s_dig;
  bit seen_a = 0;
  int hi_run = 0, last_low = -1;

  initial begin
    forever begin
      @(posedge clk);
      s_en = en; s_load = load; s_rst = rst_n; s_dig = digits;
      if (!s_rst) begin
        p = 0; pv = 0;
        sh0 = {4{7'h40}}; sh1 = {4{7'h40}}; pd0 = {4{7'h40}}; pd1 = {4{7'h40}};
        exp_fd = 0; exp_an = 4'hF; exp_d0 = 7'h40; exp_d1 = 7'h40;
      end else begin
        exp_fd = 0;
        if (s_en) begin
          p++;
          exp_fd = (p % FRAME) == 0;
          if (exp_fd && pv) begin sh0 = pd0; sh1 = pd1; pv = 0; end
        end
        if (s_load) begin pd0 = lz_proc(s_dig, 0); pd1 = lz_proc(s_dig, 1); pv = 1; end
        exp_an = 4'hF; exp_d0 = 7'h40; exp_d1 = 7'h40;
        if (s_en && (p % DV) >= GD) begin
          exp_an = ~(4'b0001 << ((p / DV) % N));
          exp_d0 = sh0[7*((p / DV) % N) +: 7];
          exp_d1 = sh1[7*((p / DV) % N) +: 7];
        end
      end
      #1;
      chk("an_n0", an0, exp_an);
      chk("an_n1", an1, exp_an);
      chk("data0", data0, exp_d0);
      chk("data1", data1, exp_d1);
      chk("fd0", fd0, exp_fd);
      chk("fd1", fd1, exp_fd);
      chk("onehot", $countones(~an0) <= 1, 1);
      if (data0 == 7'h0A) seen_a = 1;
      if (an0 == 4'hF) hi_run++;
      else begin
        if (last_low >= 0 && an0 != 4'(~(4'b0001 << last_low))) chk("guard_gap", hi_run >= GD, 1);
        for (int i = 0; i < N; i++) if (!an0[i]) last_low = i;
        hi_run = 0;
      end
    end
  end

  task automatic wait_fd();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!fd0 && n < 200);
    if (!fd0) chk("fd_timeout", 0, 1);
  endtask

  task automatic load_frame(input logic [27:0] f);
    @(negedge clk); digits = f; load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  // Called right at a frame_done sample; captures dut codes at phase 2 of each slot.
  task automatic sample_frame(output logic [27:0] f0, output logic [27:0] f1);
    repeat (2) @(posedge clk);
    #1; f0[6:0] = data0; f1[6:0] = data1;
    for (int s = 1; s < N; s++) begin
      repeat (8) @(posedge clk);
      #1; f0[7*s +: 7] = data0; f1[7*s +: 7] = data1;
    end
  endtask

  logic [3:0] an_lit [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] dat_lit [4] = '{7'h01, 7'h02, 7'h03, 7'h04};
  localparam logic [27:0] FR_C = {7'h04, 7'h03, 7'h02, 7'h01};

  initial begin
    logic [27:0] f0, f1;
    time t0, t1;
    int n;
    rst_n = 1'b0; en = 1'b1; load = 1'b0; digits = '0;
    repeat (2) @(negedge clk);
    chk("rst_an", an0, 4'hF);
    chk("rst_data", data0, 7'h40);
    chk("rst_fd", fd0, 0);
    rst_n = 1'b1;

    // Frame 4,3,2,1 with literal slot pattern
    load_frame(FR_C);
    wait_fd();
    for (int j = 0; j < FRAME; j++) begin
      if ((j % DV) < GD) begin
        chk("t2_guard_an", an0, 4'hF);
        chk("t2_guard_data", data0, 7'h40);
      end else begin
        chk("t2_on_an", an0, an_lit[j / DV]);
        chk("t2_on_data", data0, dat_lit[j / DV]);
      end
      @(posedge clk); #1;
    end
    chk("t2_fd_period", fd0, 1);

    // Asynchronous reset mid-ON
    repeat (4) @(posedge clk);
    #3;
    chk("t1_pre_an", an0, 4'hE);
    chk("t1_pre_data", data0, 7'h01);
    rst_n = 1'b0;
    #1;
    chk("t1_async_an", an0, 4'hF);
    chk("t1_async_data", data0, 7'h40);
    chk("t1_async_fd", fd0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_fd();
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_an", an0, 4'hE);
    chk("post_reset_blank", data0, 7'h40);

    // Last load wins, no tearing
    load_frame(FR_C);
    wait_fd();
    load_frame({4{7'h0A}});
    repeat (3) @(negedge clk);
    load_frame({4{7'h0B}});
    n = 0;
    do begin @(posedge clk); #1; n++; end while (an0 != 4'hB && n < 40);
    chk("t3_old_frame", data0, 7'h03);
    wait_fd();
    repeat (2) @(posedge clk);
    #1;
    chk("t3_new_frame", data0, 7'h0B);
    repeat (FRAME) @(posedge clk);
    #1;
    chk("t3_a_never_shown", seen_a, 0);

    // Leading-zero blanking
    load_frame({7'h00, 7'h00, 7'h05, 7'h00});
    wait_fd();
    sample_frame(f0, f1);
    chk("t4_lz1_a", f1, {7'h40, 7'h40, 7'h05, 7'h00});
    chk("t4_lz0_a", f0, {7'h00, 7'h00, 7'h05, 7'h00});
    load_frame({7'h20, 7'h00, 7'h05, 7'h00});
    wait_fd();
    sample_frame(f0, f1);
    chk("t4_lz1_b", f1, {7'h20, 7'h00, 7'h05, 7'h00});

    // Enable pause at idx=2, counter=4
    load_frame(FR_C);
    wait_fd();
    t0 = $time;
    repeat (20) @(posedge clk);
    @(negedge clk); en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_pause_an", an0, 4'hF);
      chk("t5_pause_data", data0, 7'h40);
    end
    en = 1'b1;
    @(negedge clk);
    chk("t5_resume_an", an0, 4'hB);
    chk("t5_resume_data", data0, 7'h03);
    repeat (2) @(negedge clk);
    chk("t5_resume_last_on", an0, 4'hB);
    @(negedge clk);
    chk("t5_resume_guard", an0, 4'hF);
    wait_fd();
    t1 = $time;
    chk("t5_period", int'((t1 - t0) / 10), FRAME + 5);

    // Random sweep: en toggling, random loads
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      en = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++)
        digits[7*i +: 7] = ($urandom_range(0, 2) == 0) ? 7'h00 : 7'($urandom_range(0, 127));
    end
    @(negedge clk);
    en = 1'b1; load = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
